wb_uart_tx: RTL

Wishbone slave UART transmitter that serialises bytes written by the CPU onto a single 8N1 line. It sits on the shared CPU Wishbone bus beside `wb_ram`; the top level decodes its address window and gates `stb_i`/`cyc_i`. It buffers bytes in a small FIFO, exposes a status register, and raises a level interrupt when transmission has drained.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 70 +++++++
 rtl/wb_uart_tx.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the Wishbone UART transmitter:
// shifter state encoding, register offsets and STATUS bit positions.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam logic [31:0] ADDR_DATA   = 32'h0000_0000;
  localparam logic [31:0] ADDR_STATUS = 32'h0000_0004;

  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_OVERFLOW  = 3;
  localparam int STAT_COUNT_LSB = 8;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with power-of-two depth.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Full is judged before any same-edge pop, so a pop never makes room for a push.
  always_comb begin
    do_push  = push_i & ~full_o;
    do_pop   = pop_i & ~empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = AW'(wr_ptr_q + 1'b1);
    end
    if (do_pop) begin
      rd_ptr_d = AW'(rd_ptr_q + 1'b1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/wb_uart_tx.sv
// Wishbone slave UART transmitter: bus slave, STATUS register, FIFO,
// bit divider and 8N1 shifter FSM with a drained-interrupt.
module wb_uart_tx
  import uart_pkg::*;
#(
  parameter int CLOCK_DIVIDE = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic        stb_i,
  input  logic        cyc_i,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic [2:0]  cti_i,
  input  logic [1:0]  bte_i,
  output logic        ack_o,
  output logic        tx_o,
  output logic        irq_o
);

  localparam int DIV_W = $clog2(CLOCK_DIVIDE);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLOCK_DIVIDE - 1);

  tx_state_e        state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             irq_q, irq_d;
  logic             ack_q, ack_d;
  logic [31:0]      dat_q, dat_d;
  logic             overflow_q, overflow_d;

  logic             accept, data_wr, status_rd;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]       fifo_rdata, count_byte;
  logic [CNT_W-1:0] fifo_count;
  logic [31:0]      status_word;
  logic             bit_end;
  logic             unused_bits;

  assign unused_bits = ^{adr_i[31:3], adr_i[1:0], dat_i[31:8], sel_i[3:1], cti_i, bte_i};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .push_i  (fifo_push),
    .wdata_i (dat_i[7:0]),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Bus slave: one access per ack pulse; STATUS read clears overflow unless a new one lands.
  always_comb begin
    accept     = cyc_i & stb_i & ~ack_q;
    data_wr    = accept & we_i & ~adr_i[2] & sel_i[0];
    status_rd  = accept & ~we_i & adr_i[2];
    fifo_push  = data_wr;
    count_byte = 8'(fifo_count);

    status_word                          = '0;
    status_word[STAT_FULL]               = fifo_full;
    status_word[STAT_EMPTY]              = fifo_empty;
    status_word[STAT_BUSY]               = (state_q != ST_IDLE);
    status_word[STAT_OVERFLOW]           = overflow_q;
    status_word[STAT_COUNT_LSB +: 8]     = count_byte;

    ack_d      = accept;
    dat_d      = status_rd ? status_word : 32'h0;
    overflow_d = overflow_q;
    if (status_rd) overflow_d = 1'b0;
    if (data_wr & fifo_full) overflow_d = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    bit_end  = (div_q == '0);

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          div_d    = DIV_LAST;
          bit_d    = 3'd0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          div_d   = DIV_LAST;
          bit_d   = 3'd0;
          state_d = ST_DATA;
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          div_d   = DIV_LAST;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = 3'(bit_q + 3'd1);
          if (bit_q == 3'd7) state_d = ST_STOP;
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      ST_STOP: begin
        // Chain straight into the next start bit so queued bytes leave with no gap.
        if (bit_end) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            div_d    = DIV_LAST;
            bit_d    = 3'd0;
            state_d  = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_q)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_q[0];
      default:  tx_d = 1'b1;
    endcase

    irq_d = fifo_empty & (state_q == ST_IDLE);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      irq_q      <= 1'b0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      irq_q      <= irq_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      overflow_q <= overflow_d;
    end
  end

  assign ack_o = ack_q;
  assign dat_o = dat_q;
  assign tx_o  = tx_q;
  assign irq_o = irq_q;

endmodule
